// File: rtl/div8_iter_sm.sv
// div8_iter_sm: 8-bit iterative divider with per-operand signedness.
// The operands are extended to 9-bit signed. The divider then takes their
// magnitudes and runs 8 restoring shift-subtract steps. After that it
// applies the result signs and registers a 9-bit signed quotient and
// remainder. A request is accepted in IDLE. The result is shown in DONE
// until the consumer takes it.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   dividend, divisor   8-bit operands
//   sign_mode           bit1: dividend signed, bit0: divisor signed
//   in_valid / in_ready request handshake (in_ready only in IDLE)
//   quotient, remainder 9-bit signed result
//   div0                divisor was zero
//   out_valid/out_ready result handshake (out_valid only in DONE)
module div8_iter_sm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  input  logic [1:0] sign_mode,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [8:0] quotient,
  output logic [8:0] remainder,
  output logic       div0,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  dvd_q, dvs_q;
  logic [1:0]  mode_q;
  logic [7:0]  aq_q;     // dividend magnitude shifts out, quotient bits shift in
  logic [7:0]  mag_b_q;
  logic [7:0]  rem_q;    // partial remainder, always < divisor magnitude
  logic        qneg_q, rneg_q, dz_q;
  logic [3:0]  cnt_q;
  logic [8:0]  quot_q, rem_out_q;
  logic        div0_q;

  // Operand extension and magnitudes. The magnitude of a 9-bit value
  // extended from 8 bits never exceeds 255, so it fits in 8 bits.
  logic [8:0] ext_a, ext_b, neg_a, neg_b;
  logic [7:0] mag_a, mag_b;
  assign ext_a = {mode_q[1] & dvd_q[7], dvd_q};
  assign ext_b = {mode_q[0] & dvs_q[7], dvs_q};
  assign neg_a = -ext_a;
  assign neg_b = -ext_b;
  assign mag_a = ext_a[8] ? neg_a[7:0] : ext_a[7:0];
  assign mag_b = ext_b[8] ? neg_b[7:0] : ext_b[7:0];

  // One restoring step. The extra top bit of diff is the borrow.
  logic [8:0] shl;
  logic [9:0] diff;
  logic       take;
  logic [7:0] rem_nxt;
  assign shl     = {rem_q, aq_q[7]};
  assign diff    = {1'b0, shl} - {2'b00, mag_b_q};
  assign take    = ~diff[9];
  assign rem_nxt = take ? diff[7:0] : shl[7:0];

  // Sign fix-up. A zero divisor overrides the result.
  logic [8:0] q9, r9, q_fix, r_fix;
  assign q9    = {1'b0, aq_q};
  assign r9    = {1'b0, rem_q};
  assign q_fix = dz_q ? 9'h1FF : (qneg_q ? -q9 : q9);
  assign r_fix = dz_q ? ext_a  : (rneg_q ? -r9 : r9);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = PREP;
      end
      PREP: state_d = ITER;
      ITER: if (cnt_q == 4'd7) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      mode_q    <= '0;
      aq_q      <= '0;
      mag_b_q   <= '0;
      rem_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_out_q <= '0;
      div0_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          dvd_q  <= dividend;
          dvs_q  <= divisor;
          mode_q <= sign_mode;
        end
        PREP: begin
          aq_q    <= mag_a;
          mag_b_q <= mag_b;
          rem_q   <= '0;
          qneg_q  <= ext_a[8] ^ ext_b[8];
          rneg_q  <= ext_a[8];
          dz_q    <= (dvs_q == 8'd0);
          cnt_q   <= '0;
        end
        ITER: begin
          rem_q <= rem_nxt;
          aq_q  <= {aq_q[6:0], take};
          cnt_q <= cnt_q + 4'd1;
        end
        FIX: begin
          quot_q    <= q_fix;
          rem_out_q <= r_fix;
          div0_q    <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_out_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_div8_iter_sm.sv
module tb_div8_iter_sm;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dividend, divisor;
  logic [1:0] sign_mode;
  logic       in_valid, in_ready;
  logic [8:0] quotient, remainder;
  logic       div0, out_valid, out_ready;

  int vectors = 0;
  int miscompares = 0;

  div8_iter_sm dut (
    .clk(clk), .rst_n(rst_n), .dividend(dividend), .divisor(divisor),
    .sign_mode(sign_mode), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .remainder(remainder), .div0(div0),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Golden model: integer division truncates toward zero, and % takes the dividend sign.
  function automatic void model(input logic [7:0] dd, input logic [7:0] ds,
                                input logic [1:0] sm, output logic [8:0] q,
                                output logic [8:0] r, output logic z);
    int a, b, qi, ri;
    a = sm[1] ? int'($signed(dd)) : int'(dd);
    b = sm[0] ? int'($signed(ds)) : int'(ds);
    if (b == 0) begin
      q = 9'h1FF; r = a[8:0]; z = 1'b1;
    end else begin
      qi = a / b; ri = a % b;
      q = qi[8:0]; r = ri[8:0]; z = 1'b0;
    end
  endfunction

  // One full operation from an IDLE cycle. Call it at #1 after a rising edge.
  // hold: cycles out_ready stays low in DONE. keep_valid: in_valid stays high with junk.
  task automatic run_op(input logic [7:0] dd, input logic [7:0] ds, input logic [1:0] sm,
                        input int hold, input bit keep_valid);
    logic [8:0] eq, er;
    logic       ez;
    int         lat;
    bit         busy_ok;
    model(dd, ds, sm, eq, er, ez);
    out_ready = (hold == 0);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL accept_ready got %b want 1", in_ready);
    end
    dividend = dd; divisor = ds; sign_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (keep_valid) begin
        dividend = 8'($urandom); divisor = 8'($urandom); sign_mode = 2'($urandom);
      end
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat != 10 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL latency got %0d want 10 (dd=%h ds=%h sm=%b)", lat, dd, ds, sm);
    end
    vectors++;
    if (!busy_ok) begin
      miscompares++; $display("FAIL busy_in_ready got 1 want 0 while computing");
    end
    vectors++;
    if (quotient !== eq || remainder !== er || div0 !== ez) begin
      miscompares++;
      $display("FAIL result dd=%h ds=%h sm=%b got q=%h r=%h z=%b want q=%h r=%h z=%b",
               dd, ds, sm, quotient, remainder, div0, eq, er, ez);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; dividend = 8'($urandom); divisor = 8'($urandom);
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, quotient, remainder, div0} !== {1'b1, 1'b0, eq, er, ez}) begin
        miscompares++;
        $display("FAIL hold cyc=%0d got v=%b rdy=%b q=%h r=%h z=%b want v=1 rdy=0 q=%h r=%h z=%b",
                 i, out_valid, in_ready, quotient, remainder, div0, eq, er, ez);
      end
    end
    if (hold > 0) in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0; sign_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, quotient, remainder, div0} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_vals got v=%b q=%h r=%h z=%b want all 0", out_valid, quotient, remainder, div0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    run_op(8'd200, 8'd7,   2'b00, 0, 1'b0);
    run_op(8'h9C,  8'd7,   2'b11, 0, 1'b0);
    run_op(8'h80,  8'hFF,  2'b10, 0, 1'b0);
    run_op(8'hFF,  8'hFF,  2'b01, 0, 1'b0);
    run_op(8'h80,  8'hFF,  2'b11, 0, 1'b0);
    run_op(8'h85,  8'h00,  2'b11, 0, 1'b0);
    run_op(8'h00,  8'h00,  2'b00, 0, 1'b0);
  endtask

  task automatic test_hold();
    run_op(8'hC3, 8'h05, 2'b10, 5, 1'b0);
  endtask

  task automatic test_reset_mid_iter();
    bit quiet;
    out_ready = 1'b1;
    dividend = 8'd250; divisor = 8'd3; sign_mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if ({out_valid, in_ready, quotient, remainder, div0} !== {1'b0, 1'b1, 19'd0}) begin
      miscompares++;
      $display("FAIL mid_reset got v=%b rdy=%b q=%h r=%h z=%b want v=0 rdy=1 zeros",
               out_valid, in_ready, quotient, remainder, div0);
    end
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++; $display("FAIL aborted_op got out_valid=1 want 0");
    end
    run_op(8'd200, 8'd7, 2'b00, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_op(8'($urandom), 8'($urandom_range(0, 255)), 2'(i), 0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] dd, ds;
    int hold;
    for (int i = 0; i < 150; i++) begin
      dd = 8'($urandom);
      ds = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) ds = 8'hFF;
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      run_op(dd, ds, 2'(i % 4), hold, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_iter();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/div8_iter_sm.md
DIV8_ITER_SM -- requirements
Module: div8_iter_sm

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 dividend  input  8  dividend operand.
REQ-005 divisor  input  8  divisor operand.
REQ-006 sign_mode  input  2  bit1=1: dividend signed; bit0=1: divisor signed (00 UU, 01 US, 10 SU, 11 SS).
REQ-007 in_valid  input  1  operands and sign_mode valid.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 quotient  output  9  signed two's-complement quotient.
REQ-010 remainder  output  9  signed two's-complement remainder.
REQ-011 div0  output  1  divisor was zero for the current result.
REQ-012 out_valid  output  1  quotient, remainder and div0 valid.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 Each operand SHALL be extended to 9-bit signed: sign-extended if its sign_mode bit is 1, zero-extended otherwise.
REQ-015 quotient SHALL be the 9-bit signed quotient truncated toward zero; remainder SHALL satisfy dividend = quotient*divisor + remainder, with |remainder| < |divisor| and remainder sign equal to the dividend sign (or zero).
REQ-016 No overflow case exists at 9 bits; e.g. SS -128/-1 SHALL give quotient +128 (9'h080), remainder 0.
REQ-017 Divisor zero SHALL give quotient 9'h1FF, remainder = extended dividend, div0=1, with the same latency as a normal operation.
REQ-018 The FSM SHALL have states IDLE, PREP, ITER, FIX, DONE.
REQ-019 in_ready SHALL be 1 exactly when the state is IDLE; a request is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-020 On acceptance, operands and sign_mode SHALL be registered and the state SHALL go IDLE->PREP; inputs in other states SHALL be ignored.
REQ-021 PREP SHALL take operand magnitudes (8-bit unsigned), record the result signs and div0, clear the 4-bit iteration counter, and go to ITER.
REQ-022 ITER SHALL perform one restoring shift-subtract step per cycle for exactly 8 cycles (counter 0..7), then go to FIX.
REQ-023 FIX SHALL apply sign correction (negate quotient if operand signs differ; remainder takes dividend sign), apply the div0 override, register outputs, and go to DONE.
REQ-024 out_valid SHALL be 1 exactly in DONE, first asserted 10 rising edges after the accepting edge.
REQ-025 In DONE, quotient/remainder/div0 SHALL hold stable while out_ready=0; with out_ready=1 the state SHALL go to IDLE and out_valid SHALL deassert on that edge.
REQ-026 Minimum spacing between accepted requests SHALL be 12 cycles (accept, 10 compute/DONE edges, 1 IDLE).
REQ-027 out_valid SHALL never be 1 in IDLE, PREP, ITER or FIX.

Reset
REQ-028 With rst_n=0 at a rising edge, the state SHALL become IDLE from any state, including mid-ITER or DONE, and any in-flight operation SHALL be discarded.
REQ-029 Reset values SHALL be: out_valid=0, quotient=0, remainder=0, div0=0, counter=0; in_ready=1 from the first cycle after reset release.
REQ-030 No result from an operation aborted by reset SHALL ever appear on the outputs.

Verification
REQ-031 UU 200/7, out_ready=1 -> after 10 edges out_valid=1, quotient=28, remainder=4, div0=0.
REQ-032 SS -100/7 -> quotient=-14 (9'h1F2), remainder=-2 (9'h1FE); SU 0x80/0xFF -> quotient=0, remainder=-128 (9'h180).
REQ-033 US 0xFF/0xFF -> quotient=-255 (9'h101), remainder=0; SS 0x80/0xFF -> quotient=128 (9'h080), remainder=0.
REQ-034 Divisor 0 with dividend 0x85 in SS -> quotient=9'h1FF, remainder=9'h185, div0=1, latency 10.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; in_valid pulses during this time are ignored.
REQ-036 Assert rst_n=0 for 1 cycle during ITER -> out_valid never asserts for that operation; next request gives the correct result at latency 10; a random sweep of all 4 modes compares against a 9-bit signed golden model, including minimum 12-cycle request spacing.
